// File: rtl/sram_bist_ctrl.sv
// Two-phase SRAM self-test: write a pattern everywhere, read it back and compare, then repeat inverted.
// Define SRAM_BIST_FAIL_LOG_EN to add the first-failure capture ports (fail_addr, fail_exp, fail_got).
module sram_bist_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [DATA_W-1:0] RW0_wdata,
    output logic              RW0_en,
    output logic              RW0_wmode,
    input  logic [DATA_W-1:0] RW0_rdata
`ifdef SRAM_BIST_FAIL_LOG_EN
    ,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
`endif
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WPRE  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int         EXT_W      = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;
    localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);

    logic [2:0]        state;
    logic              phase;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   addr_inc;
    logic              addr_last;
    logic [2:0]        drain_cnt;
    logic              start_ok;
    logic              mismatch;
    logic [15:0]       err_next;
    logic              vld_p [RD_LAT];
    logic [DATA_W-1:0] exp_p [RD_LAT];

    // Alternating ...0101 XOR the zero-extended address, inverted in phase 1.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W:0] a, input logic p);
        logic [EXT_W-1:0]  a_ext;
        logic [DATA_W-1:0] b;
        a_ext = EXT_W'(a);
        for (int i = 0; i < DATA_W; i++) begin
            b[i] = ((i % 2) == 0) ^ a_ext[i];
        end
        return p ? ~b : b;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign addr_inc  = {1'b0, addr_q} + 1'b1;
    assign addr_last = &addr_q;
    assign start_ok  = start && (state == S_IDLE || state == S_DONE);
    assign mismatch  = vld_p[RD_LAT-1] && (RW0_rdata != exp_p[RD_LAT-1]);
    assign err_next  = mismatch ? sat_inc(err_cnt) : err_cnt;
    assign RW0_addr  = addr_q;

    // Write data leads the address: the memory wrapper registers it one cycle before the write.
    always_comb begin
        busy      = 1'b0;
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_wdata = '0;
        case (state)
            S_WPRE: begin
                busy      = 1'b1;
                RW0_wdata = pattern('0, phase);
            end
            S_WRITE: begin
                busy      = 1'b1;
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_wdata = pattern(addr_inc, phase);
            end
            S_READ: begin
                busy   = 1'b1;
                RW0_en = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n) begin
            state     <= S_IDLE;
            phase     <= 1'b0;
            addr_q    <= '0;
            drain_cnt <= '0;
            err_cnt   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            // p0: read issued this cycle; last stage lines up with RW0_rdata
            vld_p[0] <= (state == S_READ);
            for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
            err_cnt <= start_ok ? 16'd0 : err_next;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state  <= S_WPRE;
                        phase  <= 1'b0;
                        addr_q <= '0;
                        done   <= 1'b0;
                        pass   <= 1'b0;
                    end
                end
                S_WPRE: state <= S_WRITE;
                S_WRITE: begin
                    addr_q <= addr_inc[ADDR_W-1:0];
                    if (addr_last) state <= S_READ;
                end
                S_READ: begin
                    addr_q <= addr_inc[ADDR_W-1:0];
                    if (addr_last) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 3'd1;
                    if (drain_cnt == DRAIN_LAST) begin
                        if (phase) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= (err_next == 16'd0);
                        end else begin
                            state <= S_WPRE;
                            phase <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge RW0_clk) begin
        exp_p[0] <= pattern({1'b0, addr_q}, phase);
        for (int i = 1; i < RD_LAT; i++) exp_p[i] <= exp_p[i-1];
    end

`ifdef SRAM_BIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] addr_p [RD_LAT];
    logic              fail_seen;

    always_ff @(posedge RW0_clk) begin
        addr_p[0] <= addr_q;
        for (int i = 1; i < RD_LAT; i++) addr_p[i] <= addr_p[i-1];
    end

    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n || start_ok) begin
            fail_seen <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (mismatch && !fail_seen) begin
            fail_seen <= 1'b1;
            fail_addr <= addr_p[RD_LAT-1];
            fail_exp  <= exp_p[RD_LAT-1];
            fail_got  <= RW0_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: two instances (read latency 2 and 4), each with a lead-write SRAM model
// and an injectable stuck-at-0 mask on read data; define SRAM_BIST_FAIL_LOG_EN to cover the failure log.
module tb_sram_bist_ctrl;
    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int NW   = 16;
    localparam int LAT0 = 2;
    localparam int LAT1 = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_v [2];
    logic          busy_v  [2];
    logic          done_v  [2];
    logic          pass_v  [2];
    logic          en_v    [2];
    logic          wm_v    [2];
    logic [15:0]   err_v   [2];
    logic [AW-1:0] addr_v  [2];
    logic [DW-1:0] wdata_v [2];
    logic [DW-1:0] rdata_v [2];
`ifdef SRAM_BIST_FAIL_LOG_EN
    logic [AW-1:0] faddr_v [2];
    logic [DW-1:0] fexp_v  [2];
    logic [DW-1:0] fgot_v  [2];
`endif
    logic [DW-1:0] mem        [2][NW];
    logic [DW-1:0] wd_prev    [2];
    logic [DW-1:0] rpipe      [2][4];
    logic [DW-1:0] stuck_mask [2];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT0)) dut0 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .start(start_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]),
        .RW0_addr(addr_v[0]), .RW0_wdata(wdata_v[0]), .RW0_en(en_v[0]),
        .RW0_wmode(wm_v[0]), .RW0_rdata(rdata_v[0])
`ifdef SRAM_BIST_FAIL_LOG_EN
        , .fail_addr(faddr_v[0]), .fail_exp(fexp_v[0]), .fail_got(fgot_v[0])
`endif
    );

    sram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT1)) dut1 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .start(start_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]),
        .RW0_addr(addr_v[1]), .RW0_wdata(wdata_v[1]), .RW0_en(en_v[1]),
        .RW0_wmode(wm_v[1]), .RW0_rdata(rdata_v[1])
`ifdef SRAM_BIST_FAIL_LOG_EN
        , .fail_addr(faddr_v[1]), .fail_exp(fexp_v[1]), .fail_got(fgot_v[1])
`endif
    );

    // Wrapper + SRAM: a write stores the data presented the previous cycle; reads return after the latency.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (en_v[k] && wm_v[k]) mem[k][addr_v[k]] <= wd_prev[k];
            wd_prev[k]  <= wdata_v[k];
            rpipe[k][0] <= mem[k][addr_v[k]];
            for (int s = 1; s < 4; s++) rpipe[k][s] <= rpipe[k][s-1];
        end
    end
    assign rdata_v[0] = rpipe[0][LAT0-1] & ~stuck_mask[0];
    assign rdata_v[1] = rpipe[1][LAT1-1] & ~stuck_mask[1];

    function automatic logic [15:0] pat(input int a, input int p);
        logic [15:0] b;
        b = 16'h5555 ^ 16'(a);
        return (p != 0) ? ~b : b;
    endfunction

    // Expected bus activity for cycle i of a run (i = 0 is the first busy cycle).
    task automatic model_cycle(input int i, input int lat, output logic en, output logic wm,
                               output logic [AW-1:0] addr, output logic [DW-1:0] wd, output logic chk_wd);
        int pl, p, j;
        pl = 1 + 2 * NW + lat;
        p  = i / pl;
        j  = i % pl;
        en = 1'b0; wm = 1'b0; addr = '0; wd = '0; chk_wd = 1'b0;
        if (j == 0) begin
            chk_wd = 1'b1; wd = pat(0, p);
        end else if (j <= NW) begin
            en = 1'b1; wm = 1'b1; addr = AW'(j - 1); chk_wd = 1'b1; wd = pat(j, p);
        end else if (j <= 2 * NW) begin
            en = 1'b1; addr = AW'(j - 1 - NW);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        stuck_mask[0] = '0; stuck_mask[1] = '0;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({busy_v[k], done_v[k], pass_v[k], en_v[k], wm_v[k]} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got busy/done/pass/en/wm=%b expected 00000", k,
                         {busy_v[k], done_v[k], pass_v[k], en_v[k], wm_v[k]});
            end
            n_checks++;
            if (err_v[k] !== 16'd0 || addr_v[k] !== '0 || wdata_v[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: got err=%0h addr=%0h wdata=%0h expected all 0", k,
                         err_v[k], addr_v[k], wdata_v[k]);
            end
`ifdef SRAM_BIST_FAIL_LOG_EN
            n_checks++;
            if (faddr_v[k] !== '0 || fexp_v[k] !== '0 || fgot_v[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_log[%0d]: got %0h/%0h/%0h expected 0/0/0", k, faddr_v[k], fexp_v[k], fgot_v[k]);
            end
`endif
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_run(input int k, input logic [15:0] mask, input string name);
        int lat, len, exp_err, first_a, first_p, bad;
        logic e_en, e_wm, chk;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        lat = (k == 0) ? LAT0 : LAT1;
        len = 2 * (1 + 2 * NW + lat);
        exp_err = 0; first_a = -1; first_p = 0;
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < NW; a++)
                if ((pat(a, p) & mask) != 16'd0) begin
                    exp_err++;
                    if (first_a < 0) begin first_a = a; first_p = p; end
                end
        stuck_mask[k] = mask;
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) tick();
            model_cycle(i, lat, e_en, e_wm, e_addr, e_wd, chk);
            n_checks++;
            if (busy_v[k] !== 1'b1 || en_v[k] !== e_en || wm_v[k] !== e_wm ||
                (e_en && addr_v[k] !== e_addr) || (chk && wdata_v[k] !== e_wd)) begin
                n_fail++;
                bad++;
                if (bad < 5)
                    $display("FAIL %s_trace[%0d]: got busy=%b en=%b wm=%b addr=%0h wd=%0h expected busy=1 en=%b wm=%b addr=%0h wd=%0h",
                             name, i, busy_v[k], en_v[k], wm_v[k], addr_v[k], wdata_v[k], e_en, e_wm, e_addr, e_wd);
            end
        end
        tick();
        n_checks++;
        if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b1 || pass_v[k] !== (exp_err == 0)) begin
            n_fail++;
            $display("FAIL %s_end: got busy=%b done=%b pass=%b expected busy=0 done=1 pass=%b",
                     name, busy_v[k], done_v[k], pass_v[k], exp_err == 0);
        end
        n_checks++;
        if (err_v[k] !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL %s_err_cnt: got %0d expected %0d", name, err_v[k], exp_err);
        end
`ifdef SRAM_BIST_FAIL_LOG_EN
        begin
            logic [AW-1:0] e_fa;
            logic [DW-1:0] e_fe, e_fg;
            e_fa = (first_a < 0) ? '0 : AW'(first_a);
            e_fe = (first_a < 0) ? '0 : pat(first_a, first_p);
            e_fg = (first_a < 0) ? '0 : (e_fe & ~mask);
            n_checks++;
            if (faddr_v[k] !== e_fa || fexp_v[k] !== e_fe || fgot_v[k] !== e_fg) begin
                n_fail++;
                $display("FAIL %s_fail_log: got %0h/%0h/%0h expected %0h/%0h/%0h",
                         name, faddr_v[k], fexp_v[k], fgot_v[k], e_fa, e_fe, e_fg);
            end
        end
`endif
    endtask

    task automatic test_write_lead();
        int cnt;
        stuck_mask[0] = '0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        n_checks++;
        if (wdata_v[0] !== 16'h5555 || en_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL lead_wpre: got wdata=%0h en=%b expected 5555 0", wdata_v[0], en_v[0]);
        end
        repeat (4) tick();
        // address 3 carries B(4) = 5555 ^ 0004
        n_checks++;
        if (addr_v[0] !== 4'd3 || wdata_v[0] !== pat(4, 0) || wm_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL lead_addr3: got addr=%0h wdata=%0h wm=%b expected 3 %0h 1", addr_v[0], wdata_v[0], wm_v[0], pat(4, 0));
        end
        cnt = 0;
        while (done_v[0] !== 1'b1 && cnt < 200) begin tick(); cnt++; end
        n_checks++;
        if (done_v[0] !== 1'b1 || pass_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL lead_done: got done=%b pass=%b expected 1 1", done_v[0], pass_v[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int cnt;
        stuck_mask[0] = 16'h0001;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (57) tick();  // phase-1 READ of address 5
        n_checks++;
        if (en_v[0] !== 1'b1 || wm_v[0] !== 1'b0 || err_v[0] < 16'd8) begin
            n_fail++;
            $display("FAIL midrun_pre: got en=%b wm=%b err=%0d expected 1 0 >=8", en_v[0], wm_v[0], err_v[0]);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (en_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || err_v[0] !== 16'd0 || done_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got en=%b busy=%b err=%0d done=%b expected 0 0 0 0", en_v[0], busy_v[0], err_v[0], done_v[0]);
        end
        rst_n = 1'b1;
        stuck_mask[0] = '0;
        tick(); tick();
        n_checks++;
        if (en_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_idle: got en=%b busy=%b expected 0 0", en_v[0], busy_v[0]);
        end
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        cnt = 0;
        while (busy_v[0] === 1'b1 && cnt < 300) begin cnt++; tick(); end
        n_checks++;
        if (cnt != 70) begin
            n_fail++;
            $display("FAIL midrun_rerun_len: got %0d busy cycles expected 70", cnt);
        end
        n_checks++;
        if (done_v[0] !== 1'b1 || pass_v[0] !== 1'b1 || err_v[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_rerun_end: got done=%b pass=%b err=%0d expected 1 1 0", done_v[0], pass_v[0], err_v[0]);
        end
    endtask

    task automatic test_start_held();
        int cnt;
        stuck_mask[0] = 16'h0001;
        start_v[0] = 1'b1;
        tick();
        cnt = 0;
        while (busy_v[0] === 1'b1 && cnt < 300) begin cnt++; tick(); end
        n_checks++;
        if (cnt != 70) begin
            n_fail++;
            $display("FAIL held_len: got %0d busy cycles expected 70", cnt);
        end
        n_checks++;
        if (done_v[0] !== 1'b1 || pass_v[0] !== 1'b0 || err_v[0] !== 16'd16) begin
            n_fail++;
            $display("FAIL held_done: got done=%b pass=%b err=%0d expected 1 0 16", done_v[0], pass_v[0], err_v[0]);
        end
        tick();
        n_checks++;
        if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0 || err_v[0] !== 16'd0 || en_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL held_restart: got busy=%b done=%b err=%0d en=%b expected 1 0 0 0", busy_v[0], done_v[0], err_v[0], en_v[0]);
        end
        start_v[0] = 1'b0;
        stuck_mask[0] = '0;
        cnt = 0;
        while (done_v[0] !== 1'b1 && cnt < 200) begin tick(); cnt++; end
        n_checks++;
        if (done_v[0] !== 1'b1 || pass_v[0] !== 1'b1 || err_v[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL held_second_run: got done=%b pass=%b err=%0d expected 1 1 0", done_v[0], pass_v[0], err_v[0]);
        end
    endtask

    initial begin
        logic [15:0] m;
        test_reset();
        test_full_run(0, 16'h0000, "clean");
        test_write_lead();
        test_full_run(0, 16'h0001, "stuck_bit0");
        for (int r = 0; r < 3; r++) begin
            m = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            if (r == 2) m = 16'($urandom);
            test_full_run(0, m, "random_fault");
        end
        test_reset_mid_run();
        test_start_held();
        test_full_run(1, 16'h0000, "lat4_clean");
        m = 16'd1 << $urandom_range(0, 15);
        test_full_run(1, m, "lat4_fault");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
